// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared AXI burst encodings and burst-master FSM states.
//   BURST_INCR - AxBURST value for incrementing bursts
//   RESP_OKAY  - xRESP value for a clean response
//   state_t    - axi_burst_master FSM encodings
package axi_burst_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;
endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst master.
//   clk_i, rst_n_i                        clock, async active-low reset
//   cmd_*                                 burst command (write flag, byte address, AXI LEN)
//   wr_data_i/wr_valid_i/wr_ready_o       write-data stream, passed straight to W
//   rd_data_o/rd_valid_o/rd_last_o/rd_ready_i  read-data stream, passed straight from R
//   done_o/done_err_o                     one-cycle completion pulse and error flag
//   AXI_AW*/AXI_W*/AXI_B*/AXI_AR*/AXI_R*  AXI4 master channels
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_P       = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
    input  logic [7:0]                    cmd_len_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wr_data_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]     rd_data_o,
    output logic                          rd_valid_o,
    output logic                          rd_last_o,
    input  logic                          rd_ready_i,
    output logic                          done_o,
    output logic                          done_err_o,
    output logic [AXI_ID_WIDTH-1:0]       AXI_AWID,
    output logic [ADDR_WIDTH-1:0]         AXI_AWADDR,
    output logic [7:0]                    AXI_AWLEN,
    output logic [2:0]                    AXI_AWSIZE,
    output logic [1:0]                    AXI_AWBURST,
    output logic                          AXI_AWLOCK,
    output logic [3:0]                    AXI_AWCACHE,
    output logic [2:0]                    AXI_AWPROT,
    output logic [3:0]                    AXI_AWQOS,
    output logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    output logic                          AXI_WLAST,
    output logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [AXI_ID_WIDTH-1:0]       AXI_BID,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    output logic                          AXI_BREADY,
    output logic [AXI_ID_WIDTH-1:0]       AXI_ARID,
    output logic [ADDR_WIDTH-1:0]         AXI_ARADDR,
    output logic [7:0]                    AXI_ARLEN,
    output logic [2:0]                    AXI_ARSIZE,
    output logic [1:0]                    AXI_ARBURST,
    output logic                          AXI_ARLOCK,
    output logic [3:0]                    AXI_ARCACHE,
    output logic [2:0]                    AXI_ARPROT,
    output logic [3:0]                    AXI_ARQOS,
    output logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]       AXI_RID,
    input  logic [AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    input  logic [1:0]                    AXI_RRESP,
    input  logic                          AXI_RLAST,
    input  logic                          AXI_RVALID,
    output logic                          AXI_RREADY
);
    localparam logic [2:0]              SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [AXI_ID_WIDTH-1:0] ID   = AXI_ID_WIDTH'(AXI_ID_P);

    state_t                state, nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, cnt;
    logic                  err, last, w_hs, r_hs;
    logic                  unused_rid;

    // RID is not checked: only one read is ever outstanding.
    assign unused_rid = ^AXI_RID;

    assign last = cnt == len_q;
    assign w_hs = AXI_WVALID && AXI_WREADY;
    assign r_hs = AXI_RVALID && AXI_RREADY;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) nxt = cmd_write_i ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (AXI_AWREADY) nxt = WR_DATA;
            WR_DATA: if (w_hs && last) nxt = WR_RESP;
            WR_RESP: if (AXI_BVALID) nxt = DONE;
            RD_ADDR: if (AXI_ARREADY) nxt = RD_DATA;
            RD_DATA: if (r_hs && last) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && cmd_valid_i) begin
                addr_q <= cmd_addr_i;
                len_q  <= cmd_len_i;
                err    <= 1'b0;
            end
            // Holding the counter clear through the address phase gives a zero count on data-state entry.
            if (state == WR_ADDR || state == RD_ADDR) cnt <= '0;
            else if (w_hs || r_hs) cnt <= cnt + 8'd1;
            if (state == WR_RESP && AXI_BVALID) err <= (AXI_BRESP != RESP_OKAY) || (AXI_BID != ID);
            if (r_hs) err <= err || (AXI_RRESP != RESP_OKAY) || (AXI_RLAST != last);
        end
    end

    assign cmd_ready_o = state == IDLE;
    assign done_o      = state == DONE;
    assign done_err_o  = state == DONE && err;

    assign AXI_AWID    = ID;
    assign AXI_AWADDR  = addr_q;
    assign AXI_AWLEN   = len_q;
    assign AXI_AWSIZE  = SIZE;
    assign AXI_AWBURST = BURST_INCR;
    assign AXI_AWLOCK  = 1'b0;
    assign AXI_AWCACHE = '0;
    assign AXI_AWPROT  = '0;
    assign AXI_AWQOS   = '0;
    assign AXI_AWVALID = state == WR_ADDR;

    assign AXI_WDATA   = wr_data_i;
    assign AXI_WSTRB   = '1;
    assign AXI_WVALID  = state == WR_DATA && wr_valid_i;
    assign AXI_WLAST   = state == WR_DATA && last;
    assign wr_ready_o  = state == WR_DATA && AXI_WREADY;
    assign AXI_BREADY  = state == WR_RESP;

    assign AXI_ARID    = ID;
    assign AXI_ARADDR  = addr_q;
    assign AXI_ARLEN   = len_q;
    assign AXI_ARSIZE  = SIZE;
    assign AXI_ARBURST = BURST_INCR;
    assign AXI_ARLOCK  = 1'b0;
    assign AXI_ARCACHE = '0;
    assign AXI_ARPROT  = '0;
    assign AXI_ARQOS   = '0;
    assign AXI_ARVALID = state == RD_ADDR;

    assign rd_data_o   = AXI_RDATA;
    assign rd_valid_o  = state == RD_DATA && AXI_RVALID;
    assign rd_last_o   = state == RD_DATA && last;
    assign AXI_RREADY  = state == RD_DATA && rd_ready_i;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bench for axi_burst_master against a small delayed-response AXI memory.
module tb_axi_burst_master;
    logic        clk = 0, rst_n = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic [31:0] wr_data = 0, rd_data;
    logic        wr_valid = 0, wr_ready, rd_valid, rd_last, rd_ready = 0, done, done_err;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rlast, rvalid, rready;
    logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
    logic        awready, wready, bvalid, arready;
    logic [31:0] mem [0:1023];
    logic [9:0]  wptr, rptr;
    logic [8:0]  rleft;
    logic [1:0]  bdly, bresp_cfg = 0;
    logic        bpend, rlast_kill = 0;
    logic [28:0] aw_f, ar_f;
    logic [31:0] aw_a, ar_a;
    int          cyc, b_cyc, aw_cnt, w_cnt, wlast_cnt;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last), .rd_ready_i(rd_ready),
        .done_o(done), .done_err_o(done_err),
        .AXI_AWID(awid), .AXI_AWADDR(awaddr), .AXI_AWLEN(awlen), .AXI_AWSIZE(awsize),
        .AXI_AWBURST(awburst), .AXI_AWLOCK(awlock), .AXI_AWCACHE(awcache), .AXI_AWPROT(awprot),
        .AXI_AWQOS(awqos), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WLAST(wlast), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BID(bid), .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARID(arid), .AXI_ARADDR(araddr), .AXI_ARLEN(arlen), .AXI_ARSIZE(arsize),
        .AXI_ARBURST(arburst), .AXI_ARLOCK(arlock), .AXI_ARCACHE(arcache), .AXI_ARPROT(arprot),
        .AXI_ARQOS(arqos), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RID(rid), .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RLAST(rlast),
        .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    // Memory model: ready pulses one cycle after valid, periodic W stalls, B two cycles late.
    assign bid    = 4'h0;
    assign bresp  = bvalid ? bresp_cfg : 2'b00;
    assign rid    = 4'h0;
    assign rresp  = 2'b00;
    assign rvalid = rleft != 0;
    assign rdata  = mem[rptr];
    assign rlast  = rleft == 1 && !rlast_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; bpend <= 0;
            bdly <= 0; wptr <= 0; rptr <= 0; rleft <= 0;
        end else begin
            cyc     <= cyc + 1;
            awready <= awvalid && !awready;
            arready <= arvalid && !arready;
            wready  <= cyc[1:0] != 2'b10;
            if (awvalid && awready) begin
                wptr <= awaddr[11:2]; aw_cnt <= aw_cnt + 1; aw_a <= awaddr;
                aw_f <= {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos};
            end
            if (wvalid && wready) begin
                mem[wptr] <= wdata; wptr <= wptr + 1; w_cnt <= w_cnt + 1;
                if (wlast) begin wlast_cnt <= wlast_cnt + 1; bpend <= 1; bdly <= 2; end
            end
            if (bpend && !bvalid) begin
                if (bdly == 0) bvalid <= 1;
                else bdly <= bdly - 1;
            end
            if (bvalid && bready) begin bvalid <= 0; bpend <= 0; b_cyc <= cyc; end
            if (arvalid && arready) begin
                rptr <= araddr[11:2]; rleft <= {1'b0, arlen} + 9'd1; ar_a <= araddr;
                ar_f <= {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos};
            end
            if (rvalid && rready) begin rptr <= rptr + 1; rleft <= rleft - 1; end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
        int n = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n == 100) chk("cmd_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wr_beats(input logic [7:0] l, input logic [31:0] base, input logic gap, input int stop);
        int beat = 0;
        for (int i = 0; i < 200 && beat <= int'(l) && beat != stop; i++) begin
            logic hs;
            wr_valid = !(gap && i % 3 == 1);
            wr_data  = base + beat;
            hs = wr_valid && wr_ready;
            if (hs) begin
                chk($sformatf("wlast_b%0d", beat), wlast, beat == int'(l));
                chk("wstrb", wstrb, 4'hF);
            end
            @(negedge clk);
            if (hs) beat++;
        end
        wr_valid = 0;
        if (beat <= int'(l) && beat != stop) chk("wr_timeout", 0, 1);
    endtask

    task automatic wait_wdone(input logic exp_err, input string tag);
        logic seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk({tag, "_err"}, done_err, exp_err);
                chk({tag, "_done_after_b"}, cyc, b_cyc + 1);
                @(negedge clk);
                chk({tag, "_done_1cyc"}, done, 0);
                chk({tag, "_idle"}, cmd_ready, 1);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic rd_collect(input logic [7:0] l, input logic [31:0] base, input logic tog,
                              input logic exp_err, input logic busy, input string tag);
        int beat = 0;
        logic seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            logic hs;
            rd_ready = tog ? logic'(i % 2) : 1'b1;
            if (done) begin
                seen = 1;
                chk({tag, "_err"}, done_err, exp_err);
                chk({tag, "_beats"}, beat, int'(l) + 1);
                if (busy) chk({tag, "_busy_at_done"}, cmd_ready, 0);
            end else begin
                if (busy) chk({tag, "_busy"}, cmd_ready, 0);
                hs = rd_valid && rd_ready;
                if (hs) begin
                    chk($sformatf("%s_data%0d", tag, beat), rd_data, base + beat);
                    chk($sformatf("%s_last%0d", tag, beat), rd_last, beat == int'(l));
                end
                @(negedge clk);
                if (hs) beat++;
            end
        end
        rd_ready = 0;
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; b_cyc = -5;
        #1 rst_n = 0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_done", {done, done_err}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        cmd(1, 32'h100, 8'd3);
        wr_beats(8'd3, 32'd1, 0, -1);
        wait_wdone(0, "wr1");
        chk("wr1_aw_count", aw_cnt, 1);
        chk("wr1_aw_addr", aw_a, 32'h100);
        chk("wr1_aw_fields", aw_f, {4'h0, 8'd3, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
        chk("wr1_w_count", w_cnt, 4);
        chk("wr1_wlast_count", wlast_cnt, 1);
        for (int k = 0; k < 4; k++) chk($sformatf("wr1_mem%0d", k), mem[64 + k], k + 1);

        cmd(0, 32'h100, 8'd3);
        rd_collect(8'd3, 32'd1, 0, 0, 0, "rd1");
        chk("rd1_ar_addr", ar_a, 32'h100);
        chk("rd1_ar_fields", ar_f, {4'h0, 8'd3, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});

        cmd(1, 32'h200, 8'd5);
        wr_beats(8'd5, 32'hA0, 1, -1);
        wait_wdone(0, "wr2");
        chk("wr2_w_count", w_cnt, 10);
        for (int k = 0; k < 6; k++) chk($sformatf("wr2_mem%0d", k), mem[128 + k], 32'hA0 + k);
        cmd(0, 32'h200, 8'd5);
        rd_collect(8'd5, 32'hA0, 1, 0, 0, "rd2");

        bresp_cfg = 2'b10;
        cmd(1, 32'h300, 8'd0);
        wr_beats(8'd0, 32'h77, 0, -1);
        wait_wdone(1, "wr_slverr");
        bresp_cfg = 2'b00;
        cmd(0, 32'h300, 8'd0);
        rd_collect(8'd0, 32'h77, 0, 0, 0, "rd_len0");

        rlast_kill = 1;
        cmd(0, 32'h100, 8'd1);
        rd_collect(8'd1, 32'd1, 0, 1, 0, "rd_nolast");
        rlast_kill = 0;

        cmd(1, 32'h400, 8'd3);
        wr_beats(8'd3, 32'hC0, 0, 2);
        wr_valid = 1;
        rst_n = 0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1; wr_valid = 0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        cmd(0, 32'h100, 8'd3);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h500; cmd_len = 8'd0;
        rd_collect(8'd3, 32'd1, 0, 0, 1, "rd_busy");
        @(negedge clk);
        chk("held_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        chk("held_cmd_awvalid", awvalid, 1);
        wr_beats(8'd0, 32'h55, 0, -1);
        wait_wdone(0, "wr_held");
        chk("wr_held_mem", mem[320], 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
